// File: rtl/eeinv_batch_arbiter.sv
// Round-robin arbiter sharing one batch-inversion engine among NREQ clients.
// Streams the owner's words into the engine and reports completion per client.
module eeinv_batch_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 272,
   parameter int AW      = 9,
   parameter int MAXW    = 32,
   parameter int BUSY_TO = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      I_REQ,
   input  logic [NREQ-1:0]      I_WVALID,
   input  logic [NREQ-1:0]      I_WLAST,
   input  logic [NREQ*AW-1:0]   I_WADDR,
   input  logic [NREQ*DW-1:0]   I_WDATA,
   output logic [NREQ-1:0]      O_WREADY,
   output logic [NREQ-1:0]      O_GNT,
   output logic [NREQ-1:0]      O_DONE,
   output logic [NREQ-1:0]      O_ERR,
   output logic                 O_INV_START,
   output logic [AW-1:0]        O_INV_WADDR,
   output logic [DW-1:0]        O_INV_WDATA,
   input  logic                 I_INV_BUSY
);

   localparam int PW  = $clog2(NREQ);
   localparam int WCW = $clog2(MAXW + 1);
   localparam int TCW = $clog2(BUSY_TO + 1);
   localparam logic [WCW-1:0] WEND = WCW'(MAXW - 1);
   localparam logic [WCW-1:0] WSAT = WCW'(MAXW);
   localparam logic [TCW-1:0] TEND = TCW'(BUSY_TO - 1);
   localparam logic [TCW-1:0] TSAT = TCW'(BUSY_TO);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_HI, WAIT_LO, DONE
   } state_t;

   state_t          state, nstate;
   logic [PW-1:0]   ptr, own, sel, ptr_nxt;
   logic            sel_ok;
   logic [NREQ-1:0] gnt;
   logic            err;
   logic [WCW-1:0]  wcnt;
   logic [TCW-1:0]  tcnt;
   logic            start;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic            wv, wl, acc, ld_end, to_hit;

   // first requester at or after the pointer, wrapping
   always_comb begin
      sel_ok = 1'b0;
      sel    = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (!sel_ok && I_REQ[(int'(ptr) + i) % NREQ]) begin
            sel_ok = 1'b1;
            sel    = PW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   assign ptr_nxt = (int'(own) == NREQ - 1) ? '0 : own + PW'(1);
   assign wv      = I_WVALID[own];
   assign wl      = I_WLAST[own];
   assign acc     = (state == LOAD) && wv;
   assign ld_end  = acc && (wl || (wcnt == WEND));
   assign to_hit  = (tcnt == TEND);

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (!I_INV_BUSY && sel_ok) nstate = LOAD;
         LOAD:    if (ld_end) nstate = WAIT_HI;
         WAIT_HI: begin
            if (I_INV_BUSY)  nstate = WAIT_LO;
            else if (to_hit) nstate = DONE;
         end
         WAIT_LO: if (!I_INV_BUSY) nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      O_WREADY    = (state == LOAD) ? gnt : '0;
      O_DONE      = (state == DONE) ? gnt : '0;
      O_ERR       = O_DONE & {NREQ{err}};
      O_GNT       = gnt;
      O_INV_START = start;
      O_INV_WADDR = waddr;
      O_INV_WDATA = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         own   <= '0;
         gnt   <= '0;
         err   <= 1'b0;
         wcnt  <= '0;
         tcnt  <= '0;
         start <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         state <= nstate;
         if (state == IDLE && nstate == LOAD) begin
            gnt <= NREQ'(1) << sel;
            own <= sel;
         end
         if (state == DONE) begin
            gnt <= '0;
            ptr <= ptr_nxt;
         end
         if (state != LOAD)
            wcnt <= '0;
         else if (acc && wcnt != WSAT)
            wcnt <= wcnt + WCW'(1);
         if (state != WAIT_HI)
            tcnt <= '0;
         else if (tcnt != TSAT)
            tcnt <= tcnt + TCW'(1);
         if (state == DONE)
            err <= 1'b0;
         else if ((ld_end && !wl) ||
                  (state == WAIT_HI && !I_INV_BUSY && to_hit))
            err <= 1'b1;
         // held through gaps so the engine re-sees the last word
         start <= (state == LOAD) && (acc || start);
         if (acc) begin
            waddr <= I_WADDR[int'(own)*AW +: AW];
            wdata <= I_WDATA[int'(own)*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_eeinv_batch_arbiter.sv
// Directed bench for eeinv_batch_arbiter: vector table for a plain batch,
// hand sequences for contention, gaps, overlength, timeout and reset.
module tb_eeinv_batch_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int AW   = 9;
   localparam int MAXW = 4;
   localparam int BTO  = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     I_REQ, I_WVALID, I_WLAST;
   logic [NREQ*AW-1:0]  I_WADDR;
   logic [NREQ*DW-1:0]  I_WDATA;
   logic [NREQ-1:0]     O_WREADY, O_GNT, O_DONE, O_ERR;
   logic                O_INV_START;
   logic [AW-1:0]       O_INV_WADDR;
   logic [DW-1:0]       O_INV_WDATA;
   logic                I_INV_BUSY;

   int ncmp = 0;
   int nbad = 0;

   eeinv_batch_arbiter #(
      .NREQ(NREQ), .DW(DW), .AW(AW), .MAXW(MAXW), .BUSY_TO(BTO)
   ) dut (
      .clk(clk), .rst(rst),
      .I_REQ(I_REQ), .I_WVALID(I_WVALID), .I_WLAST(I_WLAST),
      .I_WADDR(I_WADDR), .I_WDATA(I_WDATA),
      .O_WREADY(O_WREADY), .O_GNT(O_GNT), .O_DONE(O_DONE), .O_ERR(O_ERR),
      .O_INV_START(O_INV_START), .O_INV_WADDR(O_INV_WADDR),
      .O_INV_WDATA(O_INV_WDATA), .I_INV_BUSY(I_INV_BUSY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req, wv, wl;
      logic [8:0] a;
      logic       busy;
      logic [3:0] gnt, rdy;
      logic       st;
      logic [8:0] ea;
      logic [3:0] dn, er;
   } vec_t;

   vec_t tv[11];

   // lane k carries v + 64*k so a wrong lane mux shows up
   function automatic logic [8:0] ea(input int g, input logic [8:0] v);
      return v + 9'(g * 64);
   endfunction

   function automatic logic [15:0] ed(input int g, input logic [8:0] v);
      return {4'hA, 3'(g), ea(g, v)};
   endfunction

   task automatic word(input logic [8:0] v);
      for (int k = 0; k < NREQ; k++) begin
         I_WADDR[k*AW +: AW] = ea(k, v);
         I_WDATA[k*DW +: DW] = ed(k, v);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_word(input string nm, input int g,
                           input logic [8:0] v);
      chk(nm, {O_INV_START, O_INV_WADDR, O_INV_WDATA},
          {1'b1, ea(g, v), ed(g, v)});
   endtask

   task automatic busy_pulse();
      tick(); I_INV_BUSY = 1'b1;
      tick(); I_INV_BUSY = 1'b0;
   endtask

   task automatic wait_done(input logic [3:0] dn, input logic [3:0] er,
                            input string nm);
      int n;
      n = 0;
      smp();
      while (O_DONE == '0 && n < 30) begin
         smp();
         n++;
      end
      chk({nm, "_done"}, O_DONE, dn);
      chk({nm, "_err"}, O_ERR, er);
      tick();
      smp();
      chk({nm, "_pulse"}, O_DONE, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      //           req   wv    wl    a       busy  gnt   rdy   st    ea      dn    er
      tv[0]  = '{4'h1, 4'h0, 4'h0, 9'h000, 1'b0, 4'h0, 4'h0, 1'b0, 9'h000, 4'h0, 4'h0};
      tv[1]  = '{4'h1, 4'h1, 4'h0, 9'h011, 1'b0, 4'h1, 4'h1, 1'b0, 9'h000, 4'h0, 4'h0};
      tv[2]  = '{4'h1, 4'h1, 4'h0, 9'h012, 1'b0, 4'h1, 4'h1, 1'b1, 9'h011, 4'h0, 4'h0};
      tv[3]  = '{4'h0, 4'h1, 4'h0, 9'h013, 1'b0, 4'h1, 4'h1, 1'b1, 9'h012, 4'h0, 4'h0};
      tv[4]  = '{4'h0, 4'h1, 4'h1, 9'h015, 1'b0, 4'h1, 4'h1, 1'b1, 9'h013, 4'h0, 4'h0};
      tv[5]  = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b0, 4'h1, 4'h0, 1'b1, 9'h015, 4'h0, 4'h0};
      tv[6]  = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b1, 4'h1, 4'h0, 1'b0, 9'h000, 4'h0, 4'h0};
      tv[7]  = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b1, 4'h1, 4'h0, 1'b0, 9'h000, 4'h0, 4'h0};
      tv[8]  = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b0, 4'h1, 4'h0, 1'b0, 9'h000, 4'h0, 4'h0};
      tv[9]  = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b0, 4'h1, 4'h0, 1'b0, 9'h000, 4'h1, 4'h0};
      tv[10] = '{4'h0, 4'h0, 4'h0, 9'h000, 1'b0, 4'h0, 4'h0, 1'b0, 9'h000, 4'h0, 4'h0};

      rst = 1'b1;
      I_REQ = 4'hF; I_WVALID = 4'hF; I_WLAST = '0;
      I_INV_BUSY = 1'b0;
      word(9'h0);
      tick(); tick();
      smp();
      chk("reset_outs",
          {O_GNT, O_WREADY, O_DONE, O_ERR, O_INV_START, O_INV_WADDR, O_INV_WDATA},
          '0);
      tick();
      rst = 1'b0; I_REQ = '0; I_WVALID = '0;

      // T1: table-driven single batch on requester 0
      for (int i = 0; i < 11; i++) begin
         tick();
         I_REQ = tv[i].req; I_WVALID = tv[i].wv; I_WLAST = tv[i].wl;
         I_INV_BUSY = tv[i].busy;
         word(tv[i].a);
         smp();
         chk($sformatf("t1_row%0d", i),
             {O_GNT, O_WREADY, O_INV_START, O_DONE, O_ERR},
             {tv[i].gnt, tv[i].rdy, tv[i].st, tv[i].dn, tv[i].er});
         if (tv[i].st)
            chk($sformatf("t1_word%0d", i), {O_INV_WADDR, O_INV_WDATA},
                {tv[i].ea, ed(0, tv[i].ea)});
      end

      // T2: simultaneous req1/req2, pointer now 1
      tick(); I_REQ = 4'b0110; smp();
      chk("t2_idle", O_GNT, 4'h0);
      tick(); I_WVALID = 4'b0010; I_WLAST = 4'b0010; word(9'h05); smp();
      chk("t2_gnt1", {O_GNT, O_WREADY}, {4'b0010, 4'b0010});
      tick(); I_WVALID = '0; I_WLAST = '0; I_REQ = 4'b0100; smp();
      chk_word("t2_w1", 1, 9'h05);
      busy_pulse();
      wait_done(4'b0010, 4'h0, "t2_b1");
      chk("t2_gap_gnt", O_GNT, 4'h0);
      tick(); smp();
      chk("t2_gnt2", O_GNT, 4'b0100);
      tick(); I_WVALID = 4'b0100; I_WLAST = 4'b0100; word(9'h07); smp();
      chk("t2_rdy2", O_WREADY, 4'b0100);
      tick(); I_WVALID = '0; I_WLAST = '0; I_REQ = '0; smp();
      chk_word("t2_w2", 2, 9'h07);
      busy_pulse();
      wait_done(4'b0100, 4'h0, "t2_b2");

      // T3: gap between words on requester 3
      tick(); I_REQ = 4'b1000; smp();
      tick(); I_WVALID = 4'b1000; word(9'h22); smp();
      chk("t3_gnt", O_GNT, 4'b1000);
      tick(); I_WVALID = '0; smp();
      chk_word("t3_s1", 3, 9'h22);
      tick(); smp();
      chk_word("t3_gap", 3, 9'h22);
      tick(); I_WVALID = 4'b1000; I_WLAST = 4'b1000; word(9'h23); smp();
      chk_word("t3_s3", 3, 9'h22);
      tick(); I_WVALID = '0; I_WLAST = '0; I_REQ = '0; smp();
      chk_word("t3_s4", 3, 9'h23);
      tick(); smp();
      chk("t3_stop", O_INV_START, 1'b0);
      busy_pulse();
      wait_done(4'b1000, 4'h0, "t3");

      // T4: MAXW words without LAST, then two more offered
      tick(); I_REQ = 4'b0001; smp();
      tick(); I_WVALID = 4'b0001; word(9'h30); smp();
      chk("t4_rdy0", O_WREADY, 4'b0001);
      for (int j = 1; j < 4; j++) begin
         tick(); word(9'h30 + 9'(j)); smp();
         chk($sformatf("t4_rdy%0d", j), O_WREADY, 4'b0001);
      end
      tick(); word(9'h34); smp();
      chk("t4_rdy4", O_WREADY, 4'h0);
      chk_word("t4_last", 0, 9'h33);
      tick(); word(9'h35); smp();
      chk("t4_rdy5", {O_WREADY, O_INV_START}, 5'h0);
      tick(); I_WVALID = '0; I_REQ = '0;
      busy_pulse();
      wait_done(4'b0001, 4'b0001, "t4");

      // T5: engine never goes busy; requester 1
      tick(); I_REQ = 4'b0010; smp();
      tick(); I_WVALID = 4'b0010; I_WLAST = 4'b0010; word(9'h40); smp();
      chk("t5_rdy", O_WREADY, 4'b0010);
      for (int k = 1; k <= BTO; k++) begin
         tick(); I_WVALID = '0; I_WLAST = '0; I_REQ = '0; smp();
         chk($sformatf("t5_wait%0d", k), O_DONE, 4'h0);
      end
      tick(); smp();
      chk("t5_done", {O_DONE, O_ERR}, {4'b0010, 4'b0010});
      tick(); smp();
      chk("t5_pulse", O_DONE, 4'h0);

      // T6: reset after two words, then a clean batch
      tick(); I_REQ = 4'b0001; smp();
      tick(); I_WVALID = 4'b0001; word(9'h50); smp();
      chk("t6_gnt", O_GNT, 4'b0001);
      tick(); word(9'h51); smp();
      tick(); word(9'h52); rst = 1'b1; smp();
      chk_word("t6_pre", 0, 9'h51);
      tick(); rst = 1'b0; I_WVALID = '0; I_REQ = '0; smp();
      chk("t6_reset",
          {O_GNT, O_WREADY, O_DONE, O_ERR, O_INV_START, O_INV_WADDR, O_INV_WDATA},
          '0);
      for (int k = 0; k < 4; k++) begin
         tick(); smp();
         chk($sformatf("t6_quiet%0d", k), {O_GNT, O_DONE}, 8'h0);
      end
      tick(); I_INV_BUSY = 1'b1; I_REQ = 4'b0001; smp();
      tick(); smp();
      chk("t6_busy_block", O_GNT, 4'h0);
      tick(); I_INV_BUSY = 1'b0; smp();
      chk("t6_select", O_GNT, 4'h0);
      tick(); smp();
      chk("t6_gnt2", O_GNT, 4'b0001);
      tick(); I_WVALID = 4'b0001; I_WLAST = 4'b0001; word(9'h60); smp();
      chk("t6_rdy", O_WREADY, 4'b0001);
      tick(); I_WVALID = '0; I_WLAST = '0; I_REQ = '0; smp();
      chk_word("t6_word", 0, 9'h60);
      busy_pulse();
      wait_done(4'b0001, 4'h0, "t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
